half_bridge_sequencer: RTL and testbench

HALF_BRIDGE_SEQUENCER -- requirements
Module: half_bridge_sequencer

---
 rtl/half_bridge_sequencer.sv | 114 +++++++++++
 tb/tb_half_bridge_sequencer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/half_bridge_sequencer.sv
// Half-bridge gate sequencer: bootstrap precharge, dead-time insertion,
// minimum dwell per leg, latched fault and transition counting.
module half_bridge_sequencer #(
  parameter int DEAD_TIME = 25,
  parameter int MIN_DWELL = 100,
  parameter int BOOT_TIME = 1000
) (
  input  logic        i_clock,
  input  logic        i_RESET,
  input  logic        i_enable,
  input  logic        i_sigma,
  input  logic        i_fault,
  input  logic        i_clear_fault,
  output logic        o_gate_H,
  output logic        o_gate_L,
  output logic        o_sigma_applied,
  output logic [2:0]  o_state,
  output logic        o_fault,
  output logic [15:0] o_switch_count
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_BOOT = 3'd1;
  localparam logic [2:0] S_DTH  = 3'd2;
  localparam logic [2:0] S_HIGH = 3'd3;
  localparam logic [2:0] S_DTL  = 3'd4;
  localparam logic [2:0] S_LOW  = 3'd5;
  localparam logic [2:0] S_FLT  = 3'd6;

  // Counter reloads are length-1 so a state lasts exactly its length.
  localparam logic [15:0] LP_BOOT  = 16'(BOOT_TIME - 1);
  localparam logic [15:0] LP_DEAD  = 16'(DEAD_TIME - 1);
  localparam logic [15:0] LP_DWELL = 16'(MIN_DWELL - 1);

  logic [2:0]  r_state;
  logic [15:0] r_cnt;
  logic [15:0] r_sw_cnt;
  logic        r_gate_H;
  logic        r_gate_L;
  logic        r_sig;
  logic        r_fault;

  logic [2:0]  w_nxt;
  logic [15:0] w_cnt_nxt;
  logic        w_cnt_zero;
  logic        w_sw_inc;

  assign w_cnt_zero = (r_cnt == 16'd0);

  always_comb begin
    w_nxt = r_state;
    if (i_fault) begin
      w_nxt = S_FLT;
    end else if (r_state == S_FLT) begin
      if (i_clear_fault) w_nxt = S_IDLE;
    end else if (!i_enable) begin
      w_nxt = S_IDLE;
    end else begin
      unique case (1'b1)
        r_state == S_IDLE: w_nxt = S_BOOT;
        r_state == S_BOOT: if (w_cnt_zero) w_nxt = S_LOW;
        r_state == S_DTH:  if (w_cnt_zero) w_nxt = S_HIGH;
        r_state == S_DTL:  if (w_cnt_zero) w_nxt = S_LOW;
        r_state == S_HIGH: if (w_cnt_zero && !i_sigma) w_nxt = S_DTL;
        r_state == S_LOW:  if (w_cnt_zero && i_sigma) w_nxt = S_DTH;
        default:           w_nxt = S_IDLE;
      endcase
    end
  end

  // Shared timer: reload on any state entry, else count down to zero.
  always_comb begin
    w_cnt_nxt = w_cnt_zero ? 16'd0 : r_cnt - 16'd1;
    if (w_nxt != r_state) begin
      unique case (1'b1)
        w_nxt == S_BOOT:                    w_cnt_nxt = LP_BOOT;
        w_nxt == S_DTH || w_nxt == S_DTL:   w_cnt_nxt = LP_DEAD;
        w_nxt == S_HIGH || w_nxt == S_LOW:  w_cnt_nxt = LP_DWELL;
        default:                            w_cnt_nxt = 16'd0;
      endcase
    end
  end

  assign w_sw_inc = (r_state == S_DTH && w_nxt == S_HIGH) ||
                    (r_state == S_DTL && w_nxt == S_LOW);

  always_ff @(posedge i_clock or negedge i_RESET) begin
    if (!i_RESET) begin
      r_state  <= S_IDLE;
      r_cnt    <= 16'd0;
      r_sw_cnt <= 16'd0;
      r_gate_H <= 1'b0;
      r_gate_L <= 1'b0;
      r_sig    <= 1'b0;
      r_fault  <= 1'b0;
    end else begin
      r_state  <= w_nxt;
      r_cnt    <= w_cnt_nxt;
      r_gate_H <= (w_nxt == S_HIGH);
      r_gate_L <= (w_nxt == S_LOW) || (w_nxt == S_BOOT);
      r_sig    <= (w_nxt == S_HIGH);
      r_fault  <= (w_nxt == S_FLT);
      if (w_sw_inc) r_sw_cnt <= r_sw_cnt + 16'd1;
    end
  end

  assign o_gate_H        = r_gate_H;
  assign o_gate_L        = r_gate_L;
  assign o_sigma_applied = r_sig;
  assign o_state         = r_state;
  assign o_fault         = r_fault;
  assign o_switch_count  = r_sw_cnt;

endmodule

// File: tb/tb_half_bridge_sequencer.sv
// Directed bench for half_bridge_sequencer with DEAD=4, DWELL=8, BOOT=16.
// Gate exclusivity and dead gap are monitored every cycle.
module tb_half_bridge_sequencer;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        sigma;
  logic        flt;
  logic        clr;
  logic        gh;
  logic        gl;
  logic        sap;
  logic [2:0]  st;
  logic        ofl;
  logic [15:0] swc;

  int n_chk = 0;
  int n_err = 0;
  int gap = 0;
  int last = 0;

  half_bridge_sequencer #(
    .DEAD_TIME(4),
    .MIN_DWELL(8),
    .BOOT_TIME(16)
  ) dut (
    .i_clock(clk),
    .i_RESET(rst_n),
    .i_enable(en),
    .i_sigma(sigma),
    .i_fault(flt),
    .i_clear_fault(clr),
    .o_gate_H(gh),
    .o_gate_L(gl),
    .o_sigma_applied(sap),
    .o_state(st),
    .o_fault(ofl),
    .o_switch_count(swc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // 0 = no leg, 1 = low leg last on, 2 = high leg last on
  always @(negedge clk) begin
    if (!rst_n) begin
      last = 0;
      gap = 0;
    end else begin
      check("excl", 32'(gh & gl), 32'd0);
      if (gh) begin
        if (last == 1) check("gap_LH", 32'(gap >= 4), 32'd1);
        last = 2;
        gap = 0;
      end else if (gl) begin
        if (last == 2) check("gap_HL", 32'(gap >= 4), 32'd1);
        last = 1;
        gap = 0;
      end else begin
        gap++;
        if (st == 3'd0 || st == 3'd6) last = 0;
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    en = 1'b0;
    sigma = 1'b0;
    flt = 1'b0;
    clr = 1'b0;
    cyc(2);
    check("rst_state", 32'(st), 32'd0);
    check("rst_gates", 32'({gh, gl, sap, ofl}), 32'd0);
    check("rst_count", 32'(swc), 32'd0);

    rst_n = 1'b1;
    en = 1'b1;
    cyc(1);
    check("boot_first", 32'({st, gl, gh}), 32'({3'd1, 2'b10}));
    cyc(15);
    check("boot_last", 32'({st, gl}), 32'({3'd1, 1'b1}));
    cyc(1);
    check("low_entry", 32'({st, gl, gh}), 32'({3'd5, 2'b10}));
    check("low_count", 32'(swc), 32'd0);

    sigma = 1'b1;
    cyc(7);
    check("dwell_low", 32'({st, gl}), 32'({3'd5, 1'b1}));
    cyc(1);
    check("dth_enter", 32'({st, gl, gh}), 32'({3'd2, 2'b00}));
    cyc(3);
    check("dth_last", 32'({st, gl, gh}), 32'({3'd2, 2'b00}));
    cyc(1);
    check("high_entry", 32'({st, gh, gl, sap}), 32'({3'd3, 3'b101}));
    check("cnt_1", 32'(swc), 32'd1);

    cyc(2);
    sigma = 1'b0;
    cyc(4);
    check("dwell_high7", 32'({st, gh}), 32'({3'd3, 1'b1}));
    cyc(1);
    check("dwell_high8", 32'({st, gh}), 32'({3'd3, 1'b1}));
    cyc(1);
    check("dtl_enter", 32'({st, gh, gl, sap}), 32'({3'd4, 3'b000}));
    sigma = 1'b1;
    cyc(3);
    check("dtl_hold", 32'(st), 32'd4);
    cyc(1);
    check("low_again", 32'({st, gl}), 32'({3'd5, 1'b1}));
    check("cnt_2", 32'(swc), 32'd2);
    cyc(7);
    check("rev_dwell", 32'(st), 32'd5);
    cyc(1);
    check("rev_dth", 32'(st), 32'd2);
    cyc(4);
    check("high_2", 32'({st, gh}), 32'({3'd3, 1'b1}));
    check("cnt_3", 32'(swc), 32'd3);

    flt = 1'b1;
    cyc(1);
    flt = 1'b0;
    check("fault_enter", 32'({st, gh, gl, ofl}), 32'({3'd6, 3'b001}));
    cyc(2);
    check("fault_hold", 32'({st, ofl}), 32'({3'd6, 1'b1}));
    flt = 1'b1;
    clr = 1'b1;
    cyc(1);
    check("fault_clr_blk", 32'({st, ofl}), 32'({3'd6, 1'b1}));
    flt = 1'b0;
    cyc(1);
    clr = 1'b0;
    check("fault_exit", 32'({st, ofl}), 32'({3'd0, 1'b0}));
    check("fault_cnt", 32'(swc), 32'd3);
    cyc(1);
    check("reboot", 32'({st, gl}), 32'({3'd1, 1'b1}));
    en = 1'b0;
    cyc(1);
    check("disable", 32'({st, gh, gl}), 32'({3'd0, 2'b00}));

    en = 1'b1;
    cyc(1);
    cyc(16);
    check("low_3", 32'(st), 32'd5);
    cyc(8);
    cyc(1);
    check("dth_mid", 32'(st), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_state", 32'(st), 32'd0);
    check("async_outs", 32'({gh, gl, sap, ofl}), 32'd0);
    check("async_count", 32'(swc), 32'd0);

    cyc(1);
    rst_n = 1'b1;
    sigma = 1'b0;
    cyc(1);
    check("post_rst_boot", 32'(st), 32'd1);
    cyc(16);
    force dut.r_sw_cnt = 16'hFFFE;
    #1;
    release dut.r_sw_cnt;
    sigma = 1'b1;
    cyc(8);
    cyc(4);
    check("cnt_ffff", 32'(swc), 32'hFFFF);
    sigma = 1'b0;
    cyc(8);
    cyc(4);
    check("cnt_wrap", 32'({st, swc}), 32'({3'd5, 16'd0}));
    sigma = 1'b1;
    cyc(8);
    cyc(4);
    check("high_3", 32'({st, gh, swc}), 32'({3'd3, 1'b1, 16'd1}));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_high", 32'({st, gh, gl, sap}), 32'({3'd0, 3'b000}));
    check("async_cnt2", 32'(swc), 32'd0);
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
